// File: rtl/uart_pkg.sv
// Shared register offsets, STATUS/CTRL bit positions and shifter states for uart_tx.
package uart_pkg;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_CTRL   = 2'd2;
  localparam logic [1:0] UART_DIV    = 2'd3;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers carrying an extra MSB to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, byte FIFO, bit-time down-counter and shifter.
//   state | meaning
//   IDLE  | line high, waiting for tx_en and a queued byte
//   START | start bit (0) for one bit time
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (1); chains straight into START when more bytes wait
module uart_tx
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uartwr,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq,
  input  logic        resetirq,
  output logic        txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_lat_q, div_lat_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        irq_q, irq_d;
  logic        ovf_q, ovf_d;
  logic        tx_en_q, tx_en_d;
  logic        irq_en_q, irq_en_d;
  logic [15:0] div_q, div_d;

  logic          wr_data, wr_ctrl, wr_div;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          load, irq_set;
  logic [15:0]   div_now;
  logic [31:0]   status;

  logic unused_ok;
  assign unused_ok = ^{addr[31:4], addr[1:0], din[31:16]};

  assign wr_data   = uartwr && (addr[3:2] == UART_DATA);
  assign wr_ctrl   = uartwr && (addr[3:2] == UART_CTRL);
  assign wr_div    = uartwr && (addr[3:2] == UART_DIV);
  assign fifo_push = wr_data && !fifo_full;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (din[7:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    tx_en_d  = tx_en_q;
    irq_en_d = irq_en_q;
    div_d    = div_q;
    ovf_d    = ovf_q;
    if (wr_ctrl) begin
      tx_en_d  = din[CTRL_TX_EN];
      irq_en_d = din[CTRL_IRQ_EN];
      ovf_d    = 1'b0;
    end
    if (wr_div) div_d = din[15:0];
    if (wr_data && fifo_full) ovf_d = 1'b1;
  end

  // A zero divisor would never expire the counter, so it behaves as 1.
  assign div_now = (div_q == 16'd0) ? 16'd1 : div_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_lat_d = div_lat_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    load      = 1'b0;
    irq_set   = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (tx_en_q && !fifo_empty) load = 1'b1;
      end
      START: begin
        if (cnt_q == 16'd0) begin
          state_d = DATA;
          cnt_d   = div_lat_q - 16'd1;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = div_lat_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == 16'd0) begin
          if (tx_en_q && !fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
            irq_set = fifo_empty && irq_en_q;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      fifo_pop  = 1'b1;
      shift_d   = fifo_rdata;
      div_lat_d = div_now;
      cnt_d     = div_now - 16'd1;
      state_d   = START;
      txd_d     = 1'b0;
    end
  end

  // Set is applied last so it wins over a simultaneous clear.
  always_comb begin
    irq_d = irq_q;
    if (resetirq || wr_ctrl) irq_d = 1'b0;
    if (irq_set) irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_lat_q <= 16'd1;
      bit_q     <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      irq_q     <= 1'b0;
      ovf_q     <= 1'b0;
      tx_en_q   <= 1'b1;
      irq_en_q  <= 1'b0;
      div_q     <= DIV_RESET;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_lat_q <= div_lat_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      irq_q     <= irq_d;
      ovf_q     <= ovf_d;
      tx_en_q   <= tx_en_d;
      irq_en_q  <= irq_en_d;
      div_q     <= div_d;
    end
  end

  always_comb begin
    status                           = '0;
    status[STAT_FULL]                = fifo_full;
    status[STAT_EMPTY]               = fifo_empty;
    status[STAT_BUSY]                = (state_q != IDLE);
    status[STAT_OVF]                 = ovf_q;
    status[STAT_CNT_LSB+3:STAT_CNT_LSB] = 4'(fifo_count);
  end

  always_comb begin
    dout = '0;
    case (addr[3:2])
      UART_DATA:   dout = '0;
      UART_STATUS: dout = status;
      UART_CTRL:   dout = {30'b0, irq_en_q, tx_en_q};
      UART_DIV:    dout = {16'b0, div_q};
      default:     dout = '0;
    endcase
  end

  assign txd = txd_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: register reads, frame timing, FIFO full/overflow, irq handshake, async reset.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        uartwr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;
  logic        resetirq = 1'b0;
  logic        txd;

  int checks = 0;
  int errors = 0;

  uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd434)) dut (
    .clk      (clk),
    .reset    (reset),
    .uartwr   (uartwr),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .irq      (irq),
    .resetirq (resetirq),
    .txd      (txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write occupies exactly one clock cycle; returns at the negedge of the following cycle.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    uartwr = 1'b1; addr = a; din = d;
    @(negedge clk);
    uartwr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic frame_chk(input string tag, input logic [7:0] b, input int div);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < div; j++) begin
        chk(tag, {31'b0, txd}, {31'b0, f[k]});
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [9:0] exp_a5;
    exp_a5 = 10'b1101001010;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd_chk("rst_status", 32'h4, 32'h002);
    rd_chk("rst_ctrl",   32'h8, 32'h1);
    rd_chk("rst_div",    32'hC, 32'd434);
    rd_chk("rst_data",   32'h0, 32'h0);
    chk("rst_txd", {31'b0, txd}, 32'h1);
    chk("rst_irq", {31'b0, irq}, 32'h0);

    // DIV=4, 0xA5: start bit two cycles after the write
    wr(32'hC, 32'd4);
    wr(32'h0, 32'hA5);
    chk("a5_pre", {31'b0, txd}, 32'h1);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 4; j++) begin
        chk("a5_bit", {31'b0, txd}, {31'b0, exp_a5[k]});
        @(negedge clk);
      end
    end
    chk("a5_idle_txd", {31'b0, txd}, 32'h1);
    rd_chk("a5_idle_status", 32'h4, 32'h002);

    // DIV=2, disabled, fill FIFO then overflow
    wr(32'hC, 32'd2);
    wr(32'h8, 32'h0);
    for (int i = 1; i <= 8; i++) wr(32'h0, i);
    rd_chk("fill_status", 32'h4, 32'h801);
    wr(32'h0, 32'h99);
    rd_chk("ovf_status", 32'h4, 32'h809);
    chk("fill_txd", {31'b0, txd}, 32'h1);
    wr(32'h8, 32'h1);
    rd_chk("ovf_clear", 32'h4, 32'h801);
    @(negedge clk);
    for (int i = 1; i <= 8; i++) frame_chk("b2b_frame", 8'(i), 2);
    chk("b2b_idle_txd", {31'b0, txd}, 32'h1);
    rd_chk("b2b_idle_status", 32'h4, 32'h002);

    // irq after STOP, cleared by resetirq
    wr(32'h8, 32'h3);
    wr(32'hC, 32'd1);
    wr(32'h0, 32'hFF);
    chk("irq_pre", {31'b0, irq}, 32'h0);
    repeat (10) @(negedge clk);
    chk("irq_last_stop", {31'b0, irq}, 32'h0);
    chk("irq_stop_txd", {31'b0, txd}, 32'h1);
    @(negedge clk);
    chk("irq_set", {31'b0, irq}, 32'h1);
    resetirq = 1'b1;
    @(negedge clk);
    resetirq = 1'b0;
    chk("irq_ack", {31'b0, irq}, 32'h0);

    // resetirq coinciding with the set event: set wins
    wr(32'h0, 32'h3C);
    repeat (10) @(negedge clk);
    resetirq = 1'b1;
    @(negedge clk);
    resetirq = 1'b0;
    chk("irq_set_wins", {31'b0, irq}, 32'h1);
    wr(32'h8, 32'h1);
    chk("irq_ctrl_clear", {31'b0, irq}, 32'h0);

    // async reset mid DATA bits
    wr(32'hC, 32'd4);
    wr(32'h0, 32'h0F);
    repeat (22) @(negedge clk);
    chk("mid_txd_low", {31'b0, txd}, 32'h0);
    addr = 32'h4;
    reset = 1'b0;
    #1;
    chk("arst_txd", {31'b0, txd}, 32'h1);
    chk("arst_irq", {31'b0, irq}, 32'h0);
    chk("arst_status", dout, 32'h002);
    #1;
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      chk("post_rst_txd", {31'b0, txd}, 32'h1);
      @(negedge clk);
    end
    rd_chk("post_rst_status", 32'h4, 32'h002);
    rd_chk("post_rst_div", 32'hC, 32'd434);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Memory-mapped UART transmitter peripheral on the CPU's device bus, alongside the timer `counter`. The CPU writes bytes into the block with store instructions, and the block serialises them onto `txd` as 8N1 frames. The block raises `irq` toward the controller when its queue drains, and the controller acknowledges with `resetirq`, the same handshake the timer uses. Together with the timer, this gives the CPU an outbound serial channel.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: byte queue depth. Must be a power of two, at least 2.
- `DIV_RESET`, default 434: reset value of the baud divisor (50 MHz / 115200).

Ports:
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `uartwr` input, 1 bit: register write strobe from `ctrl`, already qualified by device-address decode.
- `addr` input, 32 bits: byte address. Only `addr[3:2]` is used; the other bits are ignored.
- `din` input, 32 bits: write data.
- `dout` output, 32 bits: combinational read data for the register selected by `addr[3:2]`.
- `irq` output, 1 bit: level interrupt request.
- `resetirq` input, 1 bit: single-cycle interrupt acknowledge from `ctrl`.
- `txd` output, 1 bit: serial line. Registered. Idle level is 1.

## Operation
Register map, selected by `addr[3:2]`:
- 0, DATA: a write pushes `din[7:0]` into the FIFO. Reads return 0.
- 1, STATUS (read-only):
  - bit0: FIFO full.
  - bit1: FIFO empty.
  - bit2: shifter busy.
  - bit3: overflow (sticky).
  - bits[11:8]: FIFO count.
  - Writes are ignored.
- 2, CTRL:
  - bit0: `tx_en`.
  - bit1: `irq_en`.
  - A write also clears overflow and `irq`.
  - Reads return `{30'b0, irq_en, tx_en}`.
- 3, DIV: bits[15:0] set the baud divisor. Reads return the divisor, zero-extended.

FIFO behaviour:
- Writing DATA while the FIFO is full drops the byte, sets overflow, and leaves the FIFO unchanged.

Shifter states:
- IDLE → START when `tx_en` is set and the FIFO is not empty. On this transition the block pops the FIFO head into the shift register and latches the current divisor.
- START: `txd` = 0 for one bit time.
- DATA: 8 bits, LSB first, one bit time each.
- STOP: `txd` = 1 for one bit time.
- From STOP:
  - Go directly to START with the next byte if `tx_en` is set and the FIFO is not empty.
  - Otherwise go to IDLE.

Divisor rules:
- One bit time is `div` cycles, using the divisor latched at frame start.
- A divisor of 0 is treated as 1.
- A DIV write during a frame affects only later frames.

Interrupt:
- `irq` is set on the cycle the shifter leaves STOP with the FIFO empty, provided `irq_en` = 1.
- `irq` is cleared by `resetirq` or by a CTRL write.
- If set and clear occur in the same cycle, set wins.

`tx_en` cleared mid-frame: the current frame completes, then the shifter stays in IDLE and the FIFO is held.

## Timing
- Reset values:
  - `txd` = 1, `irq` = 0, FIFO empty.
  - State = IDLE, overflow = 0.
  - CTRL = 0x1 (`tx_en` = 1, `irq_en` = 0).
  - DIV = `DIV_RESET`.
  - `dout` then reads STATUS = 0x002.
- A DATA write in cycle N makes the FIFO count visible in cycle N+1.
- Start from idle:
  - If the shifter is IDLE and enabled, it loads in cycle N+1.
  - `txd` falls in cycle N+2.
- Frame length is exactly 10×`div` cycles.
- Back-to-back frames have no idle gap.
- Push and pop in the same cycle: the count is unchanged.
- A push into a full FIFO is dropped even if a pop occurs in the same cycle.
- `irq` asserts in the cycle after the last STOP cycle.
- A reset assertion mid-frame returns every output to its reset value immediately and asynchronously.

## Structure
Package `uart_pkg` contains:
- Register offset constants: `UART_DATA`, `UART_STATUS`, `UART_CTRL`, `UART_DIV`.
- The STATUS and CTRL bit-position constants.
- The shifter state enum: IDLE, START, DATA, STOP.

Sub-module `sync_fifo`:
- Parameterised width and depth.
- Ports: push, pop, full, empty, count.
- Wrap-around pointers with an extra MSB.

The top-level `uart_tx` contains the register file, the bit-time counter, the bit index, the shift register, and the irq flag.

## Test plan
- Reset then read: STATUS = 0x002, CTRL = 0x1, DIV = 434, `txd` = 1, `irq` = 0.
- DIV = 4, write DATA 0xA5 → `txd` sequence is 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, and the start bit begins 2 cycles after the write.
- DIV = 2, CTRL = 0x0, write 9 bytes:
  - Count reaches 8 and full is set.
  - The 9th byte sets overflow.
  - A CTRL write of 0x1 clears overflow, and the 8 bytes then transmit back-to-back with no idle gap.
- CTRL = 0x3, DIV = 1, write one byte → `irq` = 1 the cycle after STOP; pulsing `resetirq` gives `irq` = 0 on the next cycle.
- Same-cycle `resetirq` and irq set event → `irq` remains 1.
- Assert `reset` in the middle of the DATA bits → `txd` = 1, FIFO empty, and STATUS = 0x002 immediately, with no partial frame resuming after release.
